// File: rtl/poly_pkg.sv
// Shared encodings for the Horner polynomial evaluator: control states and
// the operation codes the control FSM issues to the datapath.
package poly_pkg;

  typedef enum logic [2:0] {
    LOAD_C      = 3'd0,
    LOAD_C_WAIT = 3'd1,
    LOAD_X      = 3'd2,
    LOAD_X_WAIT = 3'd3,
    MUL         = 3'd4,
    ADD         = 3'd5,
    DONE        = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_LDX  = 3'd1,
    OP_INIT = 3'd2,
    OP_MUL  = 3'd3,
    OP_ADD  = 3'd4
  } op_e;

endpackage

// File: rtl/poly_horner_datapath.sv
// Operand storage plus the single shared multiplier and adder for Horner's rule.
// Result and overflow registers only update when control flags the final add.
module poly_horner_datapath
  import poly_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEGREE = 3,
  parameter int IDX_W  = 2
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [DEGREE:0]   coef_we_i,
  input  op_e               op_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic              res_we_i,
  output logic [DATA_W-1:0] result_o,
  output logic              ovf_o
);

  logic [DATA_W-1:0]   coef_q [0:DEGREE];
  logic [DATA_W-1:0]   x_q, acc_q, res_q;
  logic                ovf_q, res_ovf_q;
  logic [2*DATA_W-1:0] prod;
  logic [DATA_W:0]     sum;

  // Full-width product and carry-extended sum expose the overflow bits directly.
  assign prod = (2*DATA_W)'(acc_q) * (2*DATA_W)'(x_q);
  assign sum  = {1'b0, acc_q} + {1'b0, coef_q[idx_i]};

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i <= DEGREE; i++) coef_q[i] <= '0;
      x_q       <= '0;
      acc_q     <= '0;
      res_q     <= '0;
      ovf_q     <= 1'b0;
      res_ovf_q <= 1'b0;
    end else begin
      for (int i = 0; i <= DEGREE; i++) begin
        if (coef_we_i[i]) coef_q[i] <= data_i;
      end
      unique case (op_i)
        OP_LDX:  x_q <= data_i;
        OP_INIT: begin
          acc_q <= coef_q[0];
          ovf_q <= 1'b0;
        end
        OP_MUL: begin
          acc_q <= prod[DATA_W-1:0];
          ovf_q <= ovf_q | (|prod[2*DATA_W-1:DATA_W]);
        end
        OP_ADD: begin
          acc_q <= sum[DATA_W-1:0];
          ovf_q <= ovf_q | sum[DATA_W];
          if (res_we_i) begin
            res_q     <= sum[DATA_W-1:0];
            res_ovf_q <= ovf_q | sum[DATA_W];
          end
        end
        default: ;
      endcase
    end
  end

  assign result_o = res_q;
  assign ovf_o    = res_ovf_q;

endmodule

// File: rtl/poly_horner_eval.sv
// Horner polynomial evaluator: control FSM and coefficient index counter,
// driving a shared multiply/add datapath one operation per cycle.
module poly_horner_eval
  import poly_pkg::*;
#(
  parameter int  DATA_W = 8,
  parameter int  DEGREE = 3,
  localparam int IDX_W  = $clog2(DEGREE + 1)
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Go,
  input  logic              ReuseCoef,
  input  logic [DATA_W-1:0] DataIn,
  output logic [DATA_W-1:0] DataResult,
  output logic              Done,
  output logic              Busy,
  output logic              Overflow,
  output logic [IDX_W-1:0]  CoefIdx
);

  if (DEGREE < 1 || DEGREE > 15) begin : g_degree_check
    $error("poly_horner_eval: DEGREE must be in 1..15");
  end

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEGREE);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             done_q, busy_q;
  logic [DEGREE:0]  coef_we;
  op_e              op;
  logic             res_we;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    coef_we = '0;
    op      = OP_NOP;
    res_we  = 1'b0;
    unique case (state_q)
      LOAD_C: if (Go) begin
        coef_we[idx_q] = 1'b1;
        state_d        = LOAD_C_WAIT;
      end
      LOAD_C_WAIT: if (!Go) begin
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = LOAD_X;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = LOAD_C;
        end
      end
      LOAD_X: if (Go) begin
        op      = OP_LDX;
        state_d = LOAD_X_WAIT;
      end
      LOAD_X_WAIT: if (!Go) begin
        op      = OP_INIT;
        idx_d   = IDX_W'(1);
        state_d = MUL;
      end
      MUL: begin
        op      = OP_MUL;
        state_d = ADD;
      end
      ADD: begin
        op = OP_ADD;
        if (idx_q == LAST_IDX) begin
          res_we  = 1'b1;
          state_d = DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = MUL;
        end
      end
      DONE: begin
        if (ReuseCoef) begin
          state_d = LOAD_X;
        end else begin
          idx_d   = '0;
          state_d = LOAD_C;
        end
      end
      default: begin
        idx_d   = '0;
        state_d = LOAD_C;
      end
    endcase
  end

  // Done/Busy are registered from the next state so they line up with the state register.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= LOAD_C;
      idx_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= (state_d == DONE);
      busy_q  <= (state_d == MUL) || (state_d == ADD);
    end
  end

  assign Done    = done_q;
  assign Busy    = busy_q;
  assign CoefIdx = (state_q == LOAD_C || state_q == LOAD_C_WAIT) ? idx_q : '0;

  poly_horner_datapath #(
    .DATA_W (DATA_W),
    .DEGREE (DEGREE),
    .IDX_W  (IDX_W)
  ) u_datapath (
    .clk_i     (Clock),
    .rst_n_i   (Resetn),
    .data_i    (DataIn),
    .coef_we_i (coef_we),
    .op_i      (op),
    .idx_i     (idx_q),
    .res_we_i  (res_we),
    .result_o  (DataResult),
    .ovf_o     (Overflow)
  );

endmodule

// File: tb/tb_poly_horner_eval.sv
// Directed bench for poly_horner_eval: a DEGREE=3 and a DEGREE=2 instance,
// expected results queued at x-load time and checked when Done appears.
module tb_poly_horner_eval;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       go3, reuse3, go2, reuse2;
  logic [7:0] din3, din2;
  logic [7:0] res3, res2;
  logic       done3, done2, busy3, busy2, ovf3, ovf2;
  logic [1:0] cidx3, cidx2;

  poly_horner_eval #(.DATA_W(8), .DEGREE(3)) u3 (
    .Clock(clk), .Resetn(rst_n), .Go(go3), .ReuseCoef(reuse3), .DataIn(din3),
    .DataResult(res3), .Done(done3), .Busy(busy3), .Overflow(ovf3), .CoefIdx(cidx3)
  );

  poly_horner_eval #(.DATA_W(8), .DEGREE(2)) u2 (
    .Clock(clk), .Resetn(rst_n), .Go(go2), .ReuseCoef(reuse2), .DataIn(din2),
    .DataResult(res2), .Done(done2), .Busy(busy2), .Overflow(ovf2), .CoefIdx(cidx2)
  );

  typedef struct {
    logic [7:0] res;
    logic       ovf;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   sel    = 3;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] f_res();   return (sel == 3) ? res3  : res2;  endfunction
  function automatic logic       f_done();  return (sel == 3) ? done3 : done2; endfunction
  function automatic logic       f_busy();  return (sel == 3) ? busy3 : busy2; endfunction
  function automatic logic       f_ovf();   return (sel == 3) ? ovf3  : ovf2;  endfunction
  function automatic logic [1:0] f_cidx();  return (sel == 3) ? cidx3 : cidx2; endfunction

  task automatic set_go(input logic v);
    if (sel == 3) go3 = v; else go2 = v;
  endtask

  task automatic set_din(input logic [7:0] v);
    if (sel == 3) din3 = v; else din2 = v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [7:0] r, input logic o);
    exp_t e;
    e.res = r;
    e.ovf = o;
    sb.push_back(e);
  endtask

  // One Go press: value on the bus for the first cycle only, junk while Go is held.
  task automatic load_op(input logic [7:0] v, input int hold, input logic [1:0] exp_idx,
                         input string tag);
    chk({tag, "_cidx"}, 32'(f_cidx()), 32'(exp_idx));
    set_din(v);
    set_go(1'b1);
    tick();
    set_din(8'($urandom));
    repeat (hold - 1) tick();
    set_go(1'b0);
    tick();
  endtask

  task automatic wait_result(input string tag, input int deg, input logic toggle);
    int   n    = 0;
    int   nb   = 0;
    logic seen = 1'b0;
    logic g    = 1'b0;
    exp_t e;
    while (n < 64) begin
      if (f_done()) begin
        seen = 1'b1;
        break;
      end
      if (f_busy()) nb++;
      if (toggle) begin
        g = ~g;
        set_go(g);
        set_din(8'($urandom));
      end
      tick();
      n++;
    end
    set_go(1'b0);
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    chk({tag, "_latency"}, 32'(n), 32'(2 * deg));
    chk({tag, "_busy_cycles"}, 32'(nb), 32'(2 * deg));
    chk({tag, "_busy_in_done"}, 32'(f_busy()), 32'd0);
    chk({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_result"}, 32'(f_res()), 32'(e.res));
      chk({tag, "_overflow"}, 32'(f_ovf()), 32'(e.ovf));
    end
    tick();
    chk({tag, "_done_one_cycle"}, 32'(f_done()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n  = 1'b0;
    go3    = 1'b0; go2    = 1'b0;
    reuse3 = 1'b0; reuse2 = 1'b0;
    din3   = '0;   din2   = '0;
    #12;
    chk("rst_res3",  32'(res3),  32'd0);
    chk("rst_ovf3",  32'(ovf3),  32'd0);
    chk("rst_done3", 32'(done3), 32'd0);
    chk("rst_busy3", 32'(busy3), 32'd0);
    chk("rst_cidx3", 32'(cidx3), 32'd0);
    chk("rst_res2",  32'(res2),  32'd0);
    chk("rst_done2", 32'(done2), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Test 1: 1,2,3,4 with x=2; reuse coefficients afterwards
    sel    = 3;
    reuse3 = 1'b1;
    load_op(8'd1, 1, 2'd0, "t1_c0");
    load_op(8'd2, 1, 2'd1, "t1_c1");
    load_op(8'd3, 1, 2'd2, "t1_c2");
    load_op(8'd4, 1, 2'd3, "t1_c3");
    push_exp(8'd26, 1'b0);
    load_op(8'd2, 1, 2'd0, "t1_x");
    wait_result("t1", 3, 1'b0);

    // Test 2: x only, stored coefficients kept
    reuse3 = 1'b0;
    chk("t2_cidx_after_reuse", 32'(cidx3), 32'd0);
    push_exp(8'd58, 1'b0);
    load_op(8'd3, 1, 2'd0, "t2_x");
    wait_result("t2", 3, 1'b0);

    // Test 3: overflowing evaluation, then reload
    load_op(8'd10, 1, 2'd0, "t3_c0");
    load_op(8'd0,  1, 2'd1, "t3_c1");
    load_op(8'd0,  1, 2'd2, "t3_c2");
    load_op(8'd0,  1, 2'd3, "t3_c3");
    push_exp(8'd226, 1'b1);
    load_op(8'd5, 1, 2'd0, "t3_x");
    wait_result("t3a", 3, 1'b0);
    load_op(8'd0, 1, 2'd0, "t3b_c0");
    load_op(8'd0, 1, 2'd1, "t3b_c1");
    load_op(8'd0, 1, 2'd2, "t3b_c2");
    load_op(8'd7, 1, 2'd3, "t3b_c3");
    chk("t3b_res_held", 32'(res3), 32'd226);
    chk("t3b_ovf_held", 32'(ovf3), 32'd1);
    push_exp(8'd7, 1'b0);
    load_op(8'd1, 1, 2'd0, "t3b_x");
    wait_result("t3b", 3, 1'b0);

    // Test 4: DEGREE=2 instance, Go toggled during compute
    sel    = 2;
    reuse2 = 1'b0;
    load_op(8'd1, 1, 2'd0, "t4_c0");
    load_op(8'd2, 1, 2'd1, "t4_c1");
    load_op(8'd3, 1, 2'd2, "t4_c2");
    push_exp(8'd27, 1'b0);
    load_op(8'd4, 1, 2'd0, "t4_x");
    wait_result("t4", 2, 1'b1);

    // Test 5: asynchronous reset in the middle of MUL
    sel = 3;
    load_op(8'd5, 1, 2'd0, "t5_c0");
    load_op(8'd6, 1, 2'd1, "t5_c1");
    load_op(8'd7, 1, 2'd2, "t5_c2");
    load_op(8'd8, 1, 2'd3, "t5_c3");
    load_op(8'd9, 1, 2'd0, "t5_x");
    chk("t5_busy_before_rst", 32'(busy3), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_res",  32'(res3),  32'd0);
    chk("t5_rst_ovf",  32'(ovf3),  32'd0);
    chk("t5_rst_busy", 32'(busy3), 32'd0);
    chk("t5_rst_done", 32'(done3), 32'd0);
    chk("t5_rst_cidx", 32'(cidx3), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Test 6: Go held for 5 cycles per operand, junk on the bus while held
    load_op(8'd1, 5, 2'd0, "t6_c0");
    load_op(8'd1, 5, 2'd1, "t6_c1");
    load_op(8'd1, 5, 2'd2, "t6_c2");
    load_op(8'd1, 5, 2'd3, "t6_c3");
    push_exp(8'd40, 1'b0);
    load_op(8'd3, 5, 2'd0, "t6_x");
    wait_result("t6", 3, 1'b0);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
